// File: rtl/midi_note_decoder_pkg.sv
// Shared MIDI definitions.
//   note_status_t : OFF/ON
//   note_change_t : {status, key[6:0], velocity[6:0]}, 15 bits packed
//   MIDI_*        : status-nibble and byte-class constants
package midi_note_decoder_pkg;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } note_status_t;

  typedef struct packed {
    note_status_t status;
    logic [6:0]   key;
    logic [6:0]   velocity;
  } note_change_t;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [7:0] MIDI_RT_MIN   = 8'hF8;
  localparam logic [7:0] MIDI_SYS_MIN  = 8'hF0;

endpackage

// File: rtl/midi_note_decoder_if.sv
// MIDI byte in / note event out bundle.
//   midi_byte, midi_byte_valid : byte stream from the UART receiver
//   note, note_ready           : decoded event towards the polyphony dispatcher
// Handshake: both directions are pure strobes with no ready/backpressure. A
// byte is consumed in every cycle midi_byte_valid=1; note is meaningful in
// the cycle note_ready=1 and is held until the next event.
interface midi_note_decoder_if;
  import midi_note_decoder_pkg::*;

  logic [7:0]   midi_byte;
  logic         midi_byte_valid;
  note_change_t note;
  logic         note_ready;

  // master: byte source / event sink; slave: the decoder
  modport master (output midi_byte, output midi_byte_valid,
                  input  note,      input  note_ready);
  modport slave  (input  midi_byte, input  midi_byte_valid,
                  output note,      output note_ready);
endinterface

// File: rtl/midi_note_decoder.sv
// MIDI note decoder: turns the received MIDI byte stream into note events.
// Handles running status, velocity-0 Note On as Note Off, channel filtering
// and real-time bytes (which are ignored without disturbing anything).
//   clock_50_000_000 : system clock
//   reset_l          : asynchronous active-low reset
//   bus (slave)      : midi_byte/midi_byte_valid in, note/note_ready out
//   dbg_state        : current FSM state encoding
module midi_note_decoder
  import midi_note_decoder_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic                 clock_50_000_000,
  input  logic                 reset_l,
  midi_note_decoder_if.slave   bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_KEY = 3'd1,
    WAIT_VEL = 3'd2,
    SKIP1    = 3'd3,
    SKIP2_A  = 3'd4,
    SKIP2_B  = 3'd5
  } state_t;

  state_t       state_q,      state_d;
  logic         run_on_q,     run_on_d;     // running status type: 1 = Note On
  logic [6:0]   key_q,        key_d;
  note_change_t note_q,       note_d;
  logic         note_ready_q, note_ready_d;

  logic [7:0] byte_in;
  logic [3:0] hi_nib;
  logic       ch_match;

  assign byte_in  = bus.midi_byte;
  assign hi_nib   = byte_in[7:4];
  assign ch_match = OMNI || (byte_in[3:0] == CHANNEL);

  always_comb begin
    state_d      = state_q;
    run_on_d     = run_on_q;
    key_d        = key_q;
    note_d       = note_q;
    note_ready_d = 1'b0;

    if (bus.midi_byte_valid) begin
      if (byte_in >= MIDI_RT_MIN) begin
        // real-time: leave everything untouched
      end else if (byte_in >= MIDI_SYS_MIN) begin
        // system common kills running status; later data is stray
        state_d = IDLE;
      end else if (byte_in[7]) begin
        // channel status: aborts any partial message
        if ((hi_nib == MIDI_NOTE_OFF || hi_nib == MIDI_NOTE_ON) && ch_match) begin
          run_on_d = (hi_nib == MIDI_NOTE_ON);
          state_d  = WAIT_KEY;
        end else if (hi_nib == 4'hC || hi_nib == 4'hD) begin
          state_d = SKIP1;
        end else begin
          // An/Bn/En, or note messages for another channel
          state_d = SKIP2_A;
        end
      end else begin
        unique case (state_q)
          WAIT_KEY: begin
            key_d   = byte_in[6:0];
            state_d = WAIT_VEL;
          end
          WAIT_VEL: begin
            note_d.status   = (run_on_q && byte_in[6:0] != 7'd0) ? ON : OFF;
            note_d.key      = key_q;
            note_d.velocity = byte_in[6:0];
            note_ready_d    = 1'b1;
            state_d         = WAIT_KEY;
          end
          SKIP2_A: state_d = SKIP2_B;
          SKIP2_B: state_d = SKIP2_A;
          SKIP1:   state_d = SKIP1;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= IDLE;
      run_on_q     <= 1'b0;
      key_q        <= 7'd0;
      note_q       <= '0;
      note_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_on_q     <= run_on_d;
      key_q        <= key_d;
      note_q       <= note_d;
      note_ready_q <= note_ready_d;
    end
  end

  assign bus.note       = note_q;
  assign bus.note_ready = note_ready_q;
  assign dbg_state      = state_q;

endmodule
